riscv_boot_ctrl: RTL and testbench

- Sequences the single-cycle RV32I core for simulation and FPGA bring-up.
- Holds the core in reset and streams a program into instruction memory over a valid/ready load port.
- Then releases the core, counts run cycles, and stops on a core halt or a cycle-budget timeout.
- Sits between the testbench/host loader and RISCV_TOP: drives the core reset and the IMEM write port.

---
 rtl/riscv_boot_pkg.sv | 17 +
 rtl/riscv_run_timer.sv | 38 +++
 rtl/riscv_boot_ctrl.sv | 150 +++++++++++++++
 tb/tb_riscv_boot_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_boot_pkg.sv
// Shared state encoding and default sizing for the RV32I boot controller.
package riscv_boot_pkg;

    localparam int unsigned STATE_W        = 2;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_MAX_CYCLES = 1100;
    localparam int unsigned DEF_CNT_WIDTH  = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } boot_state_e;

endpackage

// File: rtl/riscv_run_timer.sv
// Run-cycle counter with terminal compare; counts only while the run continues.
module riscv_run_timer
    import riscv_boot_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_active,
    input  logic                 i_hold,
    input  logic                 i_clear,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_expire
);

    localparam logic [CNT_WIDTH-1:0] LP_TERM = CNT_WIDTH'(MAX_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_expire;

    assign w_expire = i_active && (r_cnt == LP_TERM);

    // The terminating cycle does not advance the count, so DONE shows the exit value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_active && !i_hold && !w_expire) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_expire = w_expire;

endmodule

// File: rtl/riscv_boot_ctrl.sv
// Boot sequencer: loads IMEM over valid/ready, releases the core, times the run.
// Optional feature macro: RISCV_BOOT_CHECKSUM_EN (load-data checksum accumulator).
module riscv_boot_ctrl
    import riscv_boot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rst_n,
    input  logic                  core_halt,
    input  logic                  restart,
    output logic [STATE_W-1:0]    state,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic                  done,
    output logic                  timeout,
    output logic                  overflow,
    output logic [31:0]           ld_checksum
);

    boot_state_e           r_state;
    boot_state_e           w_next_state;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic                  r_ld_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [DATA_WIDTH-1:0] r_imem_wdata;
    logic                  r_core_rst_n;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_overflow;
    logic                  w_accept;
    logic                  w_ptr_end;
    logic                  w_load_end;
    logic                  w_restart;
    logic                  w_expire;

    assign w_accept   = (r_state == ST_LOAD) && ld_valid && r_ld_ready;
    assign w_ptr_end  = (r_wptr == '1);
    assign w_load_end = w_accept && (ld_last || w_ptr_end);
    assign w_restart  = (r_state == ST_DONE) && restart;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD:  if (w_load_end) w_next_state = ST_FLUSH;
            ST_FLUSH: w_next_state = ST_RUN;
            ST_RUN:   if (core_halt || w_expire) w_next_state = ST_DONE;
            ST_DONE:  if (restart) w_next_state = ST_LOAD;
            default:  w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wptr       <= '0;
            r_ld_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Ready needs a full cycle in LOAD, so after reset or restart it rises one clock later.
            r_ld_ready   <= (r_state == ST_LOAD) && (w_next_state == ST_LOAD);
            r_core_rst_n <= (w_next_state == ST_RUN) || (w_next_state == ST_DONE);
            r_imem_we    <= w_accept;
            if (w_accept) begin
                r_imem_addr  <= r_wptr;
                r_imem_wdata <= ld_data;
                if (!w_ptr_end) r_wptr <= r_wptr + ADDR_WIDTH'(1);
                if (w_ptr_end && !ld_last) r_overflow <= 1'b1;
            end
            if ((r_state == ST_RUN) && (w_next_state == ST_DONE)) begin
                r_done    <= 1'b1;
                r_timeout <= w_expire && !core_halt;
            end
            if (w_restart) begin
                r_wptr       <= '0;
                r_imem_addr  <= '0;
                r_imem_wdata <= '0;
                r_done       <= 1'b0;
                r_timeout    <= 1'b0;
                r_overflow   <= 1'b0;
            end
        end
    end

    riscv_run_timer #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_timer (
        .i_clk    (CLK),
        .i_rst_n  (RESET),
        .i_active (r_state == ST_RUN),
        .i_hold   (core_halt),
        .i_clear  (w_restart),
        .o_cnt    (cycle_cnt),
        .o_expire (w_expire)
    );

`ifdef RISCV_BOOT_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_checksum <= '0;
        end else if (w_restart) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + 32'(ld_data);
        end
    end

    assign ld_checksum = r_checksum;
`else
    assign ld_checksum = '0;
`endif

    assign state      = r_state;
    assign ld_ready   = r_ld_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign core_rst_n = r_core_rst_n;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Self-checking bench for riscv_boot_ctrl: vector table, directed corners, randomized runs.
module tb_riscv_boot_ctrl;

    localparam int MAX = 1100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ld_valid, ld_last, core_halt, restart;
    logic [31:0] ld_data;

    logic        ld_ready, imem_we, core_rst_n, done, timeout, overflow;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata, cycle_cnt, ld_checksum;
    logic [1:0]  state;

    logic        s_ld_ready, s_imem_we, s_core_rst_n, s_done, s_timeout, s_overflow;
    logic [2:0]  s_imem_addr;
    logic [31:0] s_imem_wdata, s_cycle_cnt, s_ld_checksum;
    logic [1:0]  s_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] prog[16];
    int          wa[$];
    logic [31:0] wd[$];
    int          swa[$];
    logic [31:0] swd[$];

    always #5 CLK = ~CLK;

    riscv_boot_ctrl dut (
        .CLK(CLK), .RESET(RESET), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_halt(core_halt), .restart(restart), .state(state),
        .cycle_cnt(cycle_cnt), .done(done), .timeout(timeout), .overflow(overflow),
        .ld_checksum(ld_checksum)
    );

    riscv_boot_ctrl #(.ADDR_WIDTH(3)) dut_s (
        .CLK(CLK), .RESET(RESET), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(s_ld_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .core_rst_n(s_core_rst_n), .core_halt(core_halt),
        .restart(restart), .state(s_state), .cycle_cnt(s_cycle_cnt), .done(s_done),
        .timeout(s_timeout), .overflow(s_overflow), .ld_checksum(s_ld_checksum)
    );

    always @(negedge CLK) begin
        if (imem_we) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(imem_wdata);
        end
        if (s_imem_we) begin
            swa.push_back(int'(s_imem_addr));
            swd.push_back(s_imem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        e_rdy;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [1:0]  e_st;
        logic        e_crn;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] d, logic l, logic rdy, logic we,
                                logic [31:0] a, logic [31:0] w, logic [1:0] st, logic crn,
                                logic [31:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.e_rdy = rdy; r.e_we = we; r.e_addr = a;
        r.e_wd = w; r.e_st = st; r.e_crn = crn; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_csum(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s += prog[i];
`ifdef RISCV_BOOT_CHECKSUM_EN
        return s;
`else
        return (s & 32'h0);
`endif
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, ".state"},    64'(state),       0);
        chk({tag, ".ld_ready"}, 64'(ld_ready),    0);
        chk({tag, ".imem_we"},  64'(imem_we),     0);
        chk({tag, ".addr"},     64'(imem_addr),   0);
        chk({tag, ".wdata"},    64'(imem_wdata),  0);
        chk({tag, ".core_rst"}, 64'(core_rst_n),  0);
        chk({tag, ".cnt"},      64'(cycle_cnt),   0);
        chk({tag, ".done"},     64'(done),        0);
        chk({tag, ".timeout"},  64'(timeout),     0);
        chk({tag, ".overflow"}, 64'(overflow),    0);
        chk({tag, ".checksum"}, 64'(ld_checksum), 0);
    endtask

    task automatic clear_q();
        wa.delete(); wd.delete(); swa.delete(); swd.delete();
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        chk_rst(tag);
        clear_q();
    endtask

    // mode 0: always valid, 1: offer every other cycle, 2: random gaps; held until accepted
    task automatic send_beats(input int n, input int mode, input bit with_last, input bit sel,
                              input int budget, output int acc);
        int   cyc;
        bit   pend;
        bit   v;
        logic rdy;
        acc = 0; cyc = 0; pend = 0;
        while (acc < n && cyc < budget) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = pend || (cyc % 2 == 0);
                default: v = pend || ($urandom_range(0, 1) == 1);
            endcase
            ld_valid = v;
            ld_data  = prog[acc];
            ld_last  = with_last && (acc == n - 1);
            rdy = sel ? s_ld_ready : ld_ready;
            @(posedge CLK);
            if (v && rdy) begin
                acc++;
                pend = 0;
            end else begin
                pend = v;
            end
            @(negedge CLK);
            cyc++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic enter_run(input string tag);
        chk({tag, ".flush"}, 64'(state), 1);
        @(negedge CLK);
        chk({tag, ".run"},     64'(state),      2);
        chk({tag, ".crn"},     64'(core_rst_n), 1);
        chk({tag, ".cnt0"},    64'(cycle_cnt),  0);
    endtask

    // Starts at RUN cycle 0; halt raised k cycles in (k >= MAX means never).
    task automatic run_check(input string tag, input int k);
        logic [31:0] e_cnt;
        logic        e_to;
        e_cnt = (k < MAX) ? 32'(k) : 32'(MAX - 1);
        e_to  = (k >= MAX);
        if (k < MAX) begin
            repeat (k) @(negedge CLK);
            core_halt = 1'b1;
            @(negedge CLK);
            core_halt = 1'b0;
        end else begin
            repeat (MAX) @(negedge CLK);
        end
        chk({tag, ".state"},   64'(state),   3);
        chk({tag, ".done"},    64'(done),    1);
        chk({tag, ".timeout"}, 64'(timeout), 64'(e_to));
        chk({tag, ".cnt"},     64'(cycle_cnt), 64'(e_cnt));
        repeat (3) begin
            core_halt = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        core_halt = 1'b0;
        chk({tag, ".cnt_held"}, 64'(cycle_cnt),  64'(e_cnt));
        chk({tag, ".crn_held"}, 64'(core_rst_n), 1);
    endtask

    task automatic chk_writes(input string tag, input int n);
        #1;
        chk({tag, ".nwrites"}, 64'(wa.size()), 64'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), 64'(wa[i]), 64'(i));
            chk($sformatf("%s.data%0d", tag, i), 64'(wd[i]), 64'(prog[i]));
        end
    endtask

    vec_t tbl[8];

    initial begin
        int acc;
        int n;
        int k;

        tbl[0] = mk(1, 32'h00500093, 0, 1, 0, 0, 0,            0, 0, 0);
        tbl[1] = mk(1, 32'h00500093, 0, 1, 1, 0, 32'h00500093, 0, 0, 0);
        tbl[2] = mk(1, 32'h00100113, 0, 1, 1, 1, 32'h00100113, 0, 0, 0);
        tbl[3] = mk(0, 32'h002081B3, 0, 1, 0, 0, 0,            0, 0, 0);
        tbl[4] = mk(1, 32'h002081B3, 0, 1, 1, 2, 32'h002081B3, 0, 0, 0);
        tbl[5] = mk(1, 32'h00000073, 1, 0, 1, 3, 32'h00000073, 1, 0, 0);
        tbl[6] = mk(0, 32'h0,        0, 0, 0, 0, 0,            2, 1, 0);
        tbl[7] = mk(0, 32'h0,        0, 0, 0, 0, 0,            2, 1, 1);

        RESET = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        core_halt = 1'b0; restart = 1'b0;
        repeat (3) @(negedge CLK);
        chk_rst("por");
        RESET = 1'b1;
        clear_q();

        // Directed 4-beat load with one idle gap, through FLUSH into RUN
        for (int r = 0; r < 8; r++) begin
            ld_valid = tbl[r].v; ld_data = tbl[r].d; ld_last = tbl[r].l;
            @(negedge CLK);
            chk($sformatf("row%0d.rdy", r),   64'(ld_ready),   64'(tbl[r].e_rdy));
            chk($sformatf("row%0d.we", r),    64'(imem_we),    64'(tbl[r].e_we));
            chk($sformatf("row%0d.state", r), 64'(state),      64'(tbl[r].e_st));
            chk($sformatf("row%0d.crn", r),   64'(core_rst_n), 64'(tbl[r].e_crn));
            chk($sformatf("row%0d.cnt", r),   64'(cycle_cnt),  64'(tbl[r].e_cnt));
            if (tbl[r].e_we) begin
                chk($sformatf("row%0d.addr", r),  64'(imem_addr),  64'(tbl[r].e_addr));
                chk($sformatf("row%0d.wdata", r), 64'(imem_wdata), 64'(tbl[r].e_wd));
            end
        end
        prog[0] = 32'h00500093; prog[1] = 32'h00100113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000073;
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        chk("run_restart_ignored.state", 64'(state), 2);
        chk("run_restart_ignored.cnt", 64'(cycle_cnt), 2);
        repeat (35) @(negedge CLK);
        core_halt = 1'b1;
        @(negedge CLK);
        core_halt = 1'b0;
        chk("halt37.state", 64'(state), 3);
        chk("halt37.done", 64'(done), 1);
        chk("halt37.timeout", 64'(timeout), 0);
        chk("halt37.cnt", 64'(cycle_cnt), 37);
        repeat (3) @(negedge CLK);
        chk("halt37.cnt_held", 64'(cycle_cnt), 37);
        chk("halt37.crn_held", 64'(core_rst_n), 1);
        chk_writes("dir4", 4);
        chk("dir4.checksum", 64'(ld_checksum), 64'(exp_csum(4)));
        @(negedge CLK);
        do_restart("restart1");

        // Valid toggled every other cycle, then full budget timeout
        for (int i = 0; i < 6; i++) prog[i] = $urandom;
        send_beats(6, 1, 1'b1, 1'b0, 100, acc);
        chk("toggle.accepted", 64'(acc), 6);
        enter_run("toggle");
        run_check("timeout", MAX + 50);
        chk_writes("toggle", 6);
        do_restart("restart2");

        // Halt on the very cycle the budget expires: halt wins
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        send_beats(3, 2, 1'b1, 1'b0, 100, acc);
        chk("tie.accepted", 64'(acc), 3);
        enter_run("tie");
        run_check("tie", MAX - 1);
        do_restart("restart3");

        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            send_beats(n, 2, 1'b1, 1'b0, 200, acc);
            chk($sformatf("rnd%0d.accepted", it), 64'(acc), 64'(n));
            enter_run($sformatf("rnd%0d", it));
            k = $urandom_range(0, MAX + 150);
            run_check($sformatf("rnd%0d.k%0d", it, k), k);
            chk_writes($sformatf("rnd%0d", it), n);
            chk($sformatf("rnd%0d.checksum", it), 64'(ld_checksum), 64'(exp_csum(n)));
            do_restart($sformatf("rnd%0d.restart", it));
        end

        prog[0] = 32'd1; prog[1] = 32'd2; prog[2] = 32'd3;
        send_beats(3, 0, 1'b1, 1'b0, 50, acc);
        chk("csum.accepted", 64'(acc), 3);
        enter_run("csum");
        run_check("csum", 5);
        chk("csum.value", 64'(ld_checksum), 64'(exp_csum(3)));
        do_restart("csum.restart");

        // Asynchronous reset mid-run, then mid-load
        send_beats(2, 0, 1'b1, 1'b0, 50, acc);
        enter_run("midrun");
        repeat (10) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk_rst("midrun_reset");
        @(negedge CLK);
        RESET = 1'b1;
        prog[0] = 32'hDEADBEEF;
        send_beats(1, 0, 1'b0, 1'b0, 3, acc);
        chk("midload.accepted", 64'(acc), 1);
        RESET = 1'b0;
        #1;
        chk_rst("midload_reset");
        @(negedge CLK);
        RESET = 1'b1;
        clear_q();

        // 8-deep IMEM: 9 beats without last
        for (int i = 0; i < 9; i++) prog[i] = $urandom;
        send_beats(9, 0, 1'b0, 1'b1, 20, acc);
        chk("ovf.accepted", 64'(acc), 8);
        chk("ovf.overflow", 64'(s_overflow), 1);
        chk("ovf.ld_ready", 64'(s_ld_ready), 0);
        chk("ovf.state", 64'(s_state), 2);
        chk("ovf.crn", 64'(s_core_rst_n), 1);
        chk("ovf.nwrites", 64'(swa.size()), 8);
        for (int i = 0; i < 8 && i < swa.size(); i++) begin
            chk($sformatf("ovf.addr%0d", i), 64'(swa[i]), 64'(i));
            chk($sformatf("ovf.data%0d", i), 64'(swd[i]), 64'(prog[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
